// File: rtl/sid_dac_pkg.sv
// rtl/sid_dac_pkg.sv - SID DAC coefficient tables, state type and width check
package sid_dac_pkg;

    // Half-LSB rounding bias preloaded into the accumulator (4 fraction bits).
    localparam int ACC_BIAS = 8;

    localparam logic [11:0] SID_COEF8 [8] = '{
        12'h01d, 12'h02a, 12'h04b, 12'h08d,
        12'h110, 12'h20e, 12'h3fb, 12'h7b8
    };

    // 2R/R = 2.20 ladder without termination resistor, 4 fraction bits.
    localparam logic [15:0] SID_COEF12 [12] = '{
        16'h001d, 16'h002a, 16'h004b, 16'h008d,
        16'h0110, 16'h020e, 16'h03fb, 16'h07b8,
        16'h0f64, 16'h1ebe, 16'h3d54, 16'h7b84
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dac_state_e;

    function automatic bit legal_width(input int w);
        return (w == 8) || (w == 12);
    endfunction

endpackage

// File: rtl/sid_dac_mc_if.sv
// rtl/sid_dac_mc_if.sv - request/result bundle between requesters and the shared DAC
interface sid_dac_mc_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                         iStart;
    logic [CH_W-1:0]              iChan;
    logic [WIDTH-1:0]             iIn;
    logic                         oReady;
    logic                         oValid;
    logic [CH_W-1:0]              oChanDone;
    logic [CHANNELS*WIDTH-1:0]    oOut;

    modport master (
        output iStart, iChan, iIn,
        input  oReady, oValid, oChanDone, oOut
    );

    modport slave (
        input  iStart, iChan, iIn,
        output oReady, oValid, oChanDone, oOut
    );

endinterface

// File: rtl/sid_dac_coef_rom.sv
// rtl/sid_dac_coef_rom.sv - combinational bit-index to ladder-weight lookup
module sid_dac_coef_rom
    import sid_dac_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LINEAR = 0,
    parameter int CNT_W  = 4
) (
    input  logic [CNT_W-1:0]  count,
    output logic [WIDTH+3:0]  coef
);
    localparam int ACC_W = WIDTH + 4;

    logic [ACC_W-1:0] lut [WIDTH];

    for (genvar k = 0; k < WIDTH; k++) begin : g_lut
        if (LINEAR != 0) begin : g_lin
            assign lut[k] = ACC_W'(1) << (k + 4);
        end else if (WIDTH == 8) begin : g_tab8
            assign lut[k] = ACC_W'(SID_COEF8[k]);
        end else begin : g_tab12
            assign lut[k] = ACC_W'(SID_COEF12[k]);
        end
    end

    // Indices at or beyond WIDTH never contribute; they read as zero.
    always_comb begin
        coef = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (count == CNT_W'(k)) begin
                coef = lut[k];
            end
        end
    end

endmodule

// File: rtl/sid_dac_mc.sv
// rtl/sid_dac_mc.sv - time-multiplexed bit-serial SID DAC with per-channel held outputs
module sid_dac_mc
    import sid_dac_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int LINEAR   = 0
) (
    input  logic           clk,
    input  logic           iRst,
    sid_dac_mc_if.slave    bus
);
    localparam int ACC_W = WIDTH + 4;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!legal_width(WIDTH)) begin : g_width_check
        $error("sid_dac_mc: WIDTH must be 8 or 12");
    end

    dac_state_e                 state_q, state_d;
    logic [WIDTH-1:0]           data_q, data_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [ACC_W-1:0]           accum_q, accum_d;
    logic [CH_W-1:0]            chan_q, chan_d;
    logic [CHANNELS*WIDTH-1:0]  out_q, out_d;
    logic                       valid_q, valid_d;
    logic [CH_W-1:0]            done_q, done_d;
    logic [ACC_W-1:0]           coef;
    logic                       chan_ok;

    sid_dac_coef_rom #(
        .WIDTH  (WIDTH),
        .LINEAR (LINEAR),
        .CNT_W  (CNT_W)
    ) u_rom (
        .count  (count_q),
        .coef   (coef)
    );

    assign chan_ok = (int'(bus.iChan) < CHANNELS);

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            accum_q <= '0;
            chan_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            accum_q <= accum_d;
            chan_q  <= chan_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Conversion ends as soon as no set bits remain, so latency tracks the MSB.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        accum_d = accum_q;
        chan_d  = chan_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iStart && chan_ok) begin
                    data_d  = bus.iIn;
                    count_d = '0;
                    accum_d = ACC_W'(ACC_BIAS);
                    chan_d  = bus.iChan;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (data_q != '0) begin
                    if (data_q[0]) begin
                        accum_d = accum_q + coef;
                    end
                    data_d  = data_q >> 1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    out_d[int'(chan_q)*WIDTH +: WIDTH] = accum_q[ACC_W-1:4];
                    valid_d = 1'b1;
                    done_d  = chan_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.oReady    = (state_q == ST_IDLE);
    assign bus.oValid    = valid_q;
    assign bus.oChanDone = done_q;
    assign bus.oOut      = out_q;

endmodule

// File: tb/tb_sid_dac_mc.sv
// tb/tb_sid_dac_mc.sv - scoreboard bench for the 8-bit table and 12-bit linear DAC builds
module tb_sid_dac_mc;
    import sid_dac_pkg::*;

    typedef struct {
        int chan;
        int val;
        int lat;
        int acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst12 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_t  q8[$];
    sb_t  q12[$];
    int   exp8 [3];
    int   exp12 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sid_dac_mc_if #(.WIDTH(8),  .CHANNELS(3)) b8 ();
    sid_dac_mc_if #(.WIDTH(12), .CHANNELS(3)) b12 ();

    sid_dac_mc #(.WIDTH(8), .CHANNELS(3), .LINEAR(0)) u8 (
        .clk (clk),
        .iRst(rst8),
        .bus (b8)
    );

    sid_dac_mc #(.WIDTH(12), .CHANNELS(3), .LINEAR(1)) u12 (
        .clk (clk),
        .iRst(rst12),
        .bus (b12)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitors: every oValid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (b8.oValid === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid8_unexpected: actual=1 required=0 at cycle %0d", cyc);
            end else begin
                sb_t it;
                it = q8.pop_front();
                check("chan8", int'(b8.oChanDone), it.chan);
                check("out8", int'(b8.oOut[it.chan*8 +: 8]), it.val);
                check("lat8", cyc - it.acc, it.lat);
                exp8[it.chan] = it.val;
            end
        end
    end

    always @(negedge clk) begin
        if (b12.oValid === 1'b1) begin
            if (q12.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid12_unexpected: actual=1 required=0 at cycle %0d", cyc);
            end else begin
                sb_t it;
                it = q12.pop_front();
                check("chan12", int'(b12.oChanDone), it.chan);
                check("out12", int'(b12.oOut[it.chan*12 +: 12]), it.val);
                check("lat12", cyc - it.acc, it.lat);
                exp12[it.chan] = it.val;
            end
        end
    end

    task automatic issue(input int d, input int ch, input int code,
                         input int val, input int lat, input bit push);
        int n;
        sb_t it;
        n = 0;
        @(negedge clk);
        while (!((d == 8) ? b8.oReady : b12.oReady) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeout("ready_wait");
        if (d == 8) begin
            b8.iStart = 1'b1; b8.iChan = 2'(ch); b8.iIn = 8'(code);
        end else begin
            b12.iStart = 1'b1; b12.iChan = 2'(ch); b12.iIn = 12'(code);
        end
        @(posedge clk);
        #1;
        it = '{chan: ch, val: val, lat: lat, acc: cyc};
        if (d == 8) begin
            b8.iStart = 1'b0;
            if (push) q8.push_back(it);
        end else begin
            b12.iStart = 1'b0;
            if (push) q12.push_back(it);
        end
    endtask

    task automatic poke8(input int ch, input int code);
        @(negedge clk);
        b8.iStart = 1'b1; b8.iChan = 2'(ch); b8.iIn = 8'(code);
        @(negedge clk);
        b8.iStart = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((d == 8) ? (q8.size() != 0 || !b8.oReady)
                             : (q12.size() != 0 || !b12.oReady)) && n < 60);
        if (n >= 60) timeout("idle_wait");
    endtask

    task automatic check_all8(input string tag);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_ch%0d", tag, c), int'(b8.oOut[c*8 +: 8]), exp8[c]);
    endtask

    task automatic check_all12(input string tag);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_ch%0d", tag, c), int'(b12.oOut[c*12 +: 12]), exp12[c]);
    endtask

    initial begin
        int s8;
        int s12;
        s8 = 0;
        s12 = 0;
        for (int k = 0; k < 8; k++)  s8  += int'(SID_COEF8[k]);
        for (int k = 0; k < 12; k++) s12 += int'(SID_COEF12[k]);
        assert (s8 <= 4096 - 9) else $error("SID_COEF8 sum %0d exceeds accumulator range", s8);
        assert (s12 <= 65536 - 9) else $error("SID_COEF12 sum %0d exceeds accumulator range", s12);

        b8.iStart = 1'b0;  b8.iChan = '0;  b8.iIn = '0;
        b12.iStart = 1'b0; b12.iChan = '0; b12.iIn = '0;
        for (int c = 0; c < 3; c++) begin
            exp8[c] = 0;
            exp12[c] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready8", int'(b8.oReady), 1);
        check("rst_valid8", int'(b8.oValid), 0);
        check("rst_done8", int'(b8.oChanDone), 0);
        check("rst_out8", int'(b8.oOut), 0);
        check("rst_ready12", int'(b12.oReady), 1);
        check("rst_out12", int'(b12.oOut), 0);
        rst8 = 1'b0;
        rst12 = 1'b0;

        issue(8, 1, 8'h00, 8'h00, 1, 1'b1);
        wait_idle(8);
        issue(8, 0, 8'hFF, 8'hFF, 9, 1'b1);
        wait_idle(8);
        issue(8, 2, 8'h80, 8'h7C, 9, 1'b1);
        wait_idle(8);
        issue(8, 0, 8'h01, 8'h02, 2, 1'b1);
        wait_idle(8);
        check_all8("hold");

        // A request during RUN and one to a non-existent channel must both be dropped.
        issue(8, 1, 8'h80, 8'h7C, 9, 1'b1);
        poke8(0, 8'hFF);
        wait_idle(8);
        poke8(3, 8'hFF);
        check("badchan_ready", int'(b8.oReady), 1);
        repeat (12) @(negedge clk);
        check_all8("ignored");

        issue(8, 0, 8'hFF, 0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        for (int c = 0; c < 3; c++) exp8[c] = 0;
        check("rstrun_ready", int'(b8.oReady), 1);
        check("rstrun_valid", int'(b8.oValid), 0);
        check_all8("rstrun");
        repeat (12) @(negedge clk);
        issue(8, 2, 8'h80, 8'h7C, 9, 1'b1);
        wait_idle(8);
        check_all8("after_rst");

        issue(12, 0, 12'h800, 12'h800, 13, 1'b1);
        wait_idle(12);
        issue(12, 1, 12'h001, 12'h001, 2, 1'b1);
        wait_idle(12);
        issue(12, 2, 12'hFFF, 12'hFFF, 13, 1'b1);
        wait_idle(12);
        check_all12("lin");

        check("q8_drained", q8.size(), 0);
        check("q12_drained", q12.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_dac_mc.md
# sid_dac_mc

Parametrised, time-multiplexed bit-serial DAC model for the SID voice path. It converts WIDTH-bit codes into the non-linear R-2R output levels of the original chip, or into ideal linear levels. One shared serial accumulator serves up to CHANNELS requesters, and each channel keeps its own held output register. It sits between the voice/envelope generators and the mixer. The accumulator terminates early once the remaining input bits are zero.

## Interface
- WIDTH, 8: input code width; only 8 (envelope DAC) and 12 (waveform DAC) are legal, any other value is an elaboration error.
- CHANNELS, 3: number of held output registers.
- LINEAR, 0: 1 selects ideal binary weights instead of the R-2R table.
- ACC_W, derived as WIDTH+4: accumulator width; not overridable.
- clk  in  1  system clock.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  request; accepted only when oReady=1.
- iChan  in  $clog2(CHANNELS)  target channel, sampled with iStart.
- iIn  in  WIDTH  code, sampled with iStart.
- oReady  out  1  converter idle.
- oValid  out  1  one-cycle pulse on result write.
- oChanDone  out  $clog2(CHANNELS)  channel written when oValid=1.
- oOut  out  CHANNELS*WIDTH  held results; channel c occupies bits [c*WIDTH +: WIDTH].

## Operation
- States: IDLE and RUN.
- IDLE: oReady=1.
  - iStart=1 with iChan<CHANNELS: load data=iIn, count=0, accum=8 (half-LSB rounding bias), latch chan, go to RUN.
  - iStart=1 with iChan>=CHANNELS: ignored; stays in IDLE; no oValid.
- RUN, data!=0: accum += data[0] ? coef[count] : 0; data >>= 1; count++.
- RUN, data==0: oOut[chan] <= accum[ACC_W-1:4]; oValid=1; oChanDone=chan; go to IDLE. Other channels are unchanged.
- Coefficients:
  - LINEAR=0: coef[k] comes from the package table for WIDTH.
  - LINEAR=1: coef[k] = 1 << (k+4).
- Width rule: each table sums to at most 2^ACC_W-9, so the accumulator never wraps and no saturation logic exists. The bench asserts this at elaboration.
- iStart while in RUN is ignored; the requester must hold the request until oReady=1.
- Reset clears everything: state=IDLE, oReady=1, oValid=0, oChanDone=0, every oOut channel=0, data/count/accum=0. A reset during RUN discards the conversion, and no oValid is produced.

## Timing
- Accept edge E0.
- Let h be the index of the highest set bit of iIn. Bits 0..h accumulate at edges E1..E(h+1).
- The result and oValid are registered at edge E(h+2), so the latency is h+2 cycles.
- iIn=0 gives latency 1 (result written at E1). The maximum latency is WIDTH+1.
- oReady falls after E0 and returns high after the write edge. The next accept can therefore occur at edge E(h+3); minimum accept-to-accept spacing is latency+1.
- oValid is high for exactly one cycle per accepted request.
- oOut is registered; the old channel value holds until the write edge.

## Structure
- Package sid_dac_pkg holds:
  - SID_COEF8, the 8-entry table 12'h01d, 02a, 04b, 08d, 110, 20e, 3fb, 7b8;
  - SID_COEF12, a 12-entry 16-bit table generated by the tools script from the 2R/R=2.20, no-termination model and checked in;
  - the bias constant 8 and the function returning the legal-WIDTH check.
- Sub-module sid_dac_coef_rom (WIDTH, LINEAR): combinational count -> coef.
- This module holds the FSM, shift register, accumulator and channel registers.

## Test plan
- Zero code: WIDTH=8, LINEAR=0, iChan=1, iIn=8'h00. Required: oValid exactly 1 cycle after accept, oOut ch1 = 8'h00.
- Full scale: iIn=8'hFF, ch0. Required: accum 8+4080=4088, oOut ch0 = 8'hFF, latency 9 cycles.
- MSB non-linearity: iIn=8'h80, ch2. Required: oOut ch2 = 8'h7C. Then iIn=8'h01 on ch0: required 8'h02, latency 2. Ch2 must still read 8'h7C.
- Linear mode: WIDTH=12, LINEAR=1, iIn=12'h800. Required: oOut = 12'h800. Also iIn=12'h001: required 12'h001.
- Back-pressure and bad channel: pulse iStart during RUN, and with iChan=3 while IDLE. Required: both ignored, no extra oValid, all oOut values unchanged.
- Reset during RUN: assert iRst at E3 of an 8'hFF conversion. Required: next cycle oReady=1, oValid never asserted, all oOut=0. A fresh 8'h80 request then yields 8'h7C.
